pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard and stall sequencer for the five-stage MIPS pipeline. It drives the hold and bubble controls of the PC, the IF/ID register and the ID/EX register. Three cases are covered: load-use hazards (N bubbles inserted), taken branch/jump redirects resolved in EX (younger instructions squashed), and data-memory wait states (pipeline frozen, with a timeout). It sits beside the ID/EX register and consumes that register's EX-side control outputs.

## Interface
Parameters:
- LU_BUBBLES, 1: bubbles inserted per load-use hazard (1..7).
- MEM_TIMEOUT, 255: maximum consecutive memory-wait cycles before abort (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- rs_ID  in  5  source register rs of the instruction in ID.
- rt_ID  in  5  source register rt of the instruction in ID.
- uses_rt_ID  in  1  ID instruction reads rt.
- MemRead_EX  in  1  EX instruction is a load.
- writeAddr_EX  in  5  EX destination register.
- branch_taken_EX  in  1  EX branch resolved taken.
- Jump_EX  in  1  EX instruction is a jump.
- dmem_req  in  1  MEM stage has an active load/store.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_IF  out  1  hold the PC.
- stall_ID  out  1  hold the IF/ID register.
- bubble_EX  out  1  load zeros into the ID/EX control fields at the next edge.
- hold_EX  out  1  freeze ID/EX and all later pipeline registers.
- flush_ID  out  1  invalidate IF/ID (load a NOP).
- redirect  out  1  PC mux selects the branch/jump target.
- mem_err  out  1  sticky flag: memory-wait timeout occurred.
- stall_cycles  out  16  perf counter of load-use bubble cycles.
- flush_cycles  out  16  perf counter of redirect cycles.

## Operation
- State machine: RUN, LOADUSE, MEMWAIT. Reset state is RUN.
- Other reset values: bubble counter 0, wait counter 0, mem_err 0, both perf counters 0.
- Load-use hazard (lu_hit) = MemRead_EX & (writeAddr_EX != 0) & (writeAddr_EX == rs_ID | (uses_rt_ID & writeAddr_EX == rt_ID)).
- Memory wait (mw) = dmem_req & ~dmem_ready.
- Priority order in every cycle: mw > redirect > lu_hit.
- mw, any state:
  - outputs: stall_IF = stall_ID = hold_EX = 1; all others 0.
  - state goes to MEMWAIT; the wait counter increments.
  - An interrupted LOADUSE resumes afterwards with its bubble count preserved.
- MEMWAIT with ~mw: return to the saved state (RUN or LOADUSE) and clear the wait counter.
- Timeout: when the wait counter reaches MEM_TIMEOUT with mw still true:
  - set mem_err;
  - release hold for one cycle, so the access is treated as complete;
  - clear the counter.
  - mem_err clears only on reset.
- Redirect (branch_taken_EX | Jump_EX, no mw):
  - outputs: redirect = flush_ID = bubble_EX = 1, stall_IF = 0.
  - Any pending LOADUSE is cancelled (wrong-path instruction) and the state goes to RUN.
- lu_hit in RUN (no mw, no redirect):
  - outputs: stall_IF = stall_ID = bubble_EX = 1.
  - If LU_BUBBLES > 1, load the bubble counter with LU_BUBBLES-1 and enter LOADUSE.
  - If LU_BUBBLES = 1, stay in RUN.
- LOADUSE:
  - outputs: stall_IF = stall_ID = bubble_EX = 1; the counter decrements each cycle.
  - At 0, return to RUN; lu_hit is not re-evaluated while in LOADUSE.
- Default (no event): all control outputs 0.

## Timing
- All control outputs are combinational from state and current inputs, valid in the same cycle. Registers act on the next rising edge.
- Load-use penalty is exactly LU_BUBBLES cycles. Redirect penalty is exactly 2 instructions squashed, 1 cycle of control.
- Perf counters are registered and update at the edge following the qualifying cycle. They saturate at 0xFFFF; they do not wrap.
- Simultaneous redirect and lu_hit: redirect only, and stall_cycles does not increment.
- Reset asserted mid-MEMWAIT or mid-LOADUSE: outputs go to reset values immediately (asynchronously); nothing is resumed after release.

## Configuration
- HAZ_PERF_CNT_EN:
  - Defined: stall_cycles and flush_cycles are implemented as described.
  - Undefined: no counter flops; both ports are driven constant 0.
- Hazard behaviour is identical in both builds.

## Test plan
- Load-use, LU_BUBBLES=1: MemRead_EX=1, writeAddr_EX=5, rs_ID=5 for one cycle. Required: stall_IF/stall_ID/bubble_EX high for exactly 1 cycle; stall_cycles goes 0 -> 1.
- No false hazard: writeAddr_EX=0 with rs_ID=0 gives no stall. rt match with uses_rt_ID=0 gives no stall.
- Redirect overrides load-use: branch_taken_EX=1 in the same cycle as a load-use match. Required: redirect/flush_ID/bubble_EX=1, stall_IF=0; flush_cycles=1, stall_cycles=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then ready. Required: hold_EX=1 for exactly 3 cycles; mem_err stays 0; state returns to RUN.
- Timeout with MEM_TIMEOUT=4 and ready never asserted: hold_EX high for 4 cycles, then low for 1 cycle; mem_err=1 and stays 1 until rst_n is pulsed low.
- LU_BUBBLES=3 with a memory wait injected in the 2nd bubble: 3 bubble cycles in total, separated by the hold cycles. Asserting rst_n low mid-sequence forces all outputs to 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, EX redirects, dmem waits.
// Optional perf counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int LU_BUBBLES  = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        uses_rt_ID,
    input  logic        MemRead_EX,
    input  logic [4:0]  writeAddr_EX,
    input  logic        branch_taken_EX,
    input  logic        Jump_EX,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall_IF,
    output logic        stall_ID,
    output logic        bubble_EX,
    output logic        hold_EX,
    output logic        flush_ID,
    output logic        redirect,
    output logic        mem_err,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_cycles
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOADUSE = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [2:0] LU_LOAD  = 3'(LU_BUBBLES - 1);
    localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);

    state_t      state_r, state_s;
    state_t      saved_r, saved_s;
    state_t      base_s;
    logic [2:0]  bub_cnt_r, bub_cnt_s;
    logic [7:0]  wait_cnt_r, wait_cnt_s;
    logic        mem_err_r, mem_err_s;

    logic        lu_hit_s, mw_s, redir_s, timeout_s, mw_eff_s;
    logic        stall_if_s, stall_id_s, bubble_ex_s, hold_ex_s, flush_id_s, redirect_s;

    assign lu_hit_s  = MemRead_EX && (writeAddr_EX != 5'd0) &&
                       ((writeAddr_EX == rs_ID) || (uses_rt_ID && (writeAddr_EX == rt_ID)));
    assign mw_s      = dmem_req && !dmem_ready;
    assign redir_s   = branch_taken_EX || Jump_EX;
    // A timed-out access is released for one cycle as if the memory had answered.
    assign timeout_s = mw_s && (state_r == ST_MEMWAIT) && (wait_cnt_r >= WAIT_MAX);
    assign mw_eff_s  = mw_s && !timeout_s;

    // Behavioural state underneath a memory wait: the state that was interrupted.
    always_comb begin
        if (state_r == ST_MEMWAIT) begin
            base_s = saved_r;
        end else begin
            base_s = state_r;
        end
    end

    // Next-state and control-output decode with mw > redirect > load-use priority.
    always_comb begin
        stall_if_s  = 1'b0;
        stall_id_s  = 1'b0;
        bubble_ex_s = 1'b0;
        hold_ex_s   = 1'b0;
        flush_id_s  = 1'b0;
        redirect_s  = 1'b0;
        state_s     = state_r;
        saved_s     = saved_r;
        bub_cnt_s   = bub_cnt_r;
        wait_cnt_s  = wait_cnt_r;
        mem_err_s   = mem_err_r;
        if (mw_eff_s) begin
            stall_if_s = 1'b1;
            stall_id_s = 1'b1;
            hold_ex_s  = 1'b1;
            state_s    = ST_MEMWAIT;
            saved_s    = base_s;
            wait_cnt_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_s = 8'd0;
            saved_s    = ST_RUN;
            if (timeout_s) begin
                mem_err_s = 1'b1;
            end else begin
                mem_err_s = mem_err_r;
            end
            if (redir_s) begin
                redirect_s  = 1'b1;
                flush_id_s  = 1'b1;
                bubble_ex_s = 1'b1;
                state_s     = ST_RUN;
                bub_cnt_s   = 3'd0;
            end else begin
                case (base_s)
                    ST_LOADUSE: begin
                        stall_if_s  = 1'b1;
                        stall_id_s  = 1'b1;
                        bubble_ex_s = 1'b1;
                        if (bub_cnt_r <= 3'd1) begin
                            state_s   = ST_RUN;
                            bub_cnt_s = 3'd0;
                        end else begin
                            state_s   = ST_LOADUSE;
                            bub_cnt_s = bub_cnt_r - 3'd1;
                        end
                    end
                    ST_RUN: begin
                        if (lu_hit_s) begin
                            stall_if_s  = 1'b1;
                            stall_id_s  = 1'b1;
                            bubble_ex_s = 1'b1;
                            if (LU_BUBBLES > 1) begin
                                state_s   = ST_LOADUSE;
                                bub_cnt_s = LU_LOAD;
                            end else begin
                                state_s   = ST_RUN;
                                bub_cnt_s = 3'd0;
                            end
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                    default: begin
                        state_s   = ST_RUN;
                        bub_cnt_s = 3'd0;
                    end
                endcase
            end
        end
    end

    // Sequencer state, counters and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            saved_r    <= ST_RUN;
            bub_cnt_r  <= 3'd0;
            wait_cnt_r <= 8'd0;
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            saved_r    <= saved_s;
            bub_cnt_r  <= bub_cnt_s;
            wait_cnt_r <= wait_cnt_s;
            mem_err_r  <= mem_err_s;
        end
    end

    // Gating with rst_n forces the controls quiet the moment reset is applied.
    assign stall_IF  = rst_n & stall_if_s;
    assign stall_ID  = rst_n & stall_id_s;
    assign bubble_EX = rst_n & bubble_ex_s;
    assign hold_EX   = rst_n & hold_ex_s;
    assign flush_ID  = rst_n & flush_id_s;
    assign redirect  = rst_n & redirect_s;
    assign mem_err   = mem_err_r;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_r, flush_cnt_r;
    logic        lu_evt_s, rd_evt_s;

    assign lu_evt_s = bubble_ex_s & ~redirect_s;
    assign rd_evt_s = redirect_s;

    // Saturating perf counters for load-use bubble and redirect cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (lu_evt_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
            if (rd_evt_s && (flush_cnt_r != 16'hFFFF)) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_r;
    assign flush_cycles = flush_cnt_r;
`else
    assign stall_cycles = 16'd0;
    assign flush_cycles = 16'd0;
`endif

endmodule
